mips_cpu_writeback_unit: RTL and testbench
==========================================

// Module: mips_cpu_writeback_unit
// PURPOSE
//  Write-side driver for the 32x32 register file: accepts one retiring instruction at a time,
//  selects its result (ALU, load, link, HI/LO move) and produces a single-cycle registered
//  write_enable/write_reg/write_data pulse. Loads wait on the data-memory handshake and are
//  byte-extracted / sign-extended / LWL-LWR merged here. Stalls upstream via busy.
// PARAMETERS
//  DATA_W     32  datapath width (only 32 supported)
//  CNT_W      32  width of retired-instruction counter
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low reset
//  wb_valid       in   1   retiring instruction presented this cycle
//  wb_src         in   2   0=ALU, 1=LOAD, 2=LINK, 3=HILO
//  dest_reg       in   5   destination register index
//  alu_result     in   32  ALU result
//  link_addr      in   32  return address (PC+8)
//  hilo_value     in   32  MFHI/MFLO value
//  load_type      in   3   0=LW 1=LB 2=LBU 3=LH 4=LHU 5=LWL 6=LWR (7 treated as LW)
//  byte_addr      in   2   effective address [1:0] of the load
//  rt_old         in   32  current rt contents, for LWL/LWR merge
//  mem_readdata   in   32  data-memory read data
//  mem_waitrequest in  1   1 = mem_readdata not yet valid
//  busy           out  1   1 = unit cannot accept wb_valid this cycle
//  write_enable   out  1   register-file write strobe (one cycle)
//  write_reg      out  5   register-file write index
//  write_data     out  32  register-file write data
//  wb_done        out  1   one-cycle pulse per retired instruction (incl. dest 0)
//  retired_count  out  CNT_W  instructions retired since reset, wraps to 0
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; busy, write_enable, wb_done = 0; write_reg = 0;
//   write_data = 0; retired_count = 0. Any in-flight load is discarded, no write issued.
//  FSM: IDLE -> (accept LOAD) WAIT_MEM -> (mem_waitrequest=0) COMMIT -> IDLE.
//   Non-load accepts go IDLE -> COMMIT -> IDLE. All outputs are registered.
//  Accept: wb_valid && !busy. dest_reg, wb_src, load_type, byte_addr, rt_old and the
//   selected non-load result are captured at accept; later input changes are ignored.
//  busy = 1 in WAIT_MEM and COMMIT; wb_valid while busy is ignored (upstream holds it).
//  Latency: non-load: accept at edge N -> write_enable/wb_done high for cycle N+1 only.
//   Load: mem_readdata sampled on first edge in WAIT_MEM with mem_waitrequest=0
//   (earliest edge N+1); write pulse in the following cycle. No timeout on waitrequest.
//  Back-to-back: a new accept is possible in the cycle after COMMIT (one bubble per instr).
//  dest_reg=0: write_enable stays 0, write_reg/write_data still updated, wb_done pulses.
//  write_reg/write_data hold their last value when write_enable=0.
//  Load extraction (little-endian lanes, k=byte_addr):
//   LB/LBU: byte mem[8k+7:8k], sign-/zero-extended. LH/LHU: half selected by k[1],
//   k[0] ignored, sign-/zero-extended. LW: mem unchanged, k ignored.
//   LWL: (mem << 8*(3-k)) | (rt_old & (2^(8*(3-k)) - 1)).
//   LWR: (mem >> 8*k)     | (rt_old & ~(2^(32-8k) - 1))   (k=0 -> mem entirely).
//  retired_count increments by 1 in each wb_done cycle; wraps 2^CNT_W-1 -> 0.
// TESTING
//  Reset asserted mid-WAIT_MEM -> busy=0 immediately, no write pulse after release, count=0.
//  ALU: wb_valid, src=0, dest=8, alu_result=0x1234_5678 -> next cycle we=1, reg=8,
//   data=0x1234_5678, busy=1 for exactly one cycle, count=1.
//  LB, byte_addr=2, mem=0x00F3_0000, waitrequest high 3 cycles -> busy held 4+ cycles,
//   then we=1, data=0xFFFF_FFF3; LBU same -> 0x0000_00F3.
//  LWL k=1, mem=0xAABB_CCDD, rt_old=0x1122_3344 -> 0xCCDD_3344;
//   LWR k=1 same inputs -> 0x11AA_BBCC.
//  LINK dest=0 -> we=0, wb_done=1, count increments; wb_valid pulsed while busy is dropped.
//  Preload retired_count to 0xFFFF_FFFF via 2^32-1 retires (or forced) -> next retire wraps to 0.

Source files
------------

// File: rtl/mips_cpu_writeback_unit_if.sv
// ============================================================================
//  Module      : mips_cpu_writeback_unit_if
//  Description : Retire/memory/register-file bundle for the writeback unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_cpu_writeback_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              wb_valid;
    logic [1:0]        wb_src;
    logic [4:0]        dest_reg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] link_addr;
    logic [DATA_W-1:0] hilo_value;
    logic [2:0]        load_type;
    logic [1:0]        byte_addr;
    logic [DATA_W-1:0] rt_old;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_waitrequest;
    logic              busy;
    logic              write_enable;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;
    logic              wb_done;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output wb_valid, wb_src, dest_reg, alu_result, link_addr, hilo_value,
               load_type, byte_addr, rt_old, mem_readdata, mem_waitrequest,
        input  busy, write_enable, write_reg, write_data, wb_done, retired_count
    );

    modport slave (
        input  wb_valid, wb_src, dest_reg, alu_result, link_addr, hilo_value,
               load_type, byte_addr, rt_old, mem_readdata, mem_waitrequest,
        output busy, write_enable, write_reg, write_data, wb_done, retired_count
    );
endinterface

`default_nettype wire

// File: rtl/mips_cpu_writeback_unit.sv
// ============================================================================
//  Module      : mips_cpu_writeback_unit
//  Description : Register-file write driver: result select, load extraction,
//                registered single-cycle write pulse and retire counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_cpu_writeback_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_cpu_writeback_unit_if.slave wb
);
    localparam logic [1:0] C_SRC_ALU  = 2'd0;
    localparam logic [1:0] C_SRC_LOAD = 2'd1;
    localparam logic [1:0] C_SRC_LINK = 2'd2;
    localparam logic [2:0] C_LT_LB    = 3'd1;
    localparam logic [2:0] C_LT_LBU   = 3'd2;
    localparam logic [2:0] C_LT_LH    = 3'd3;
    localparam logic [2:0] C_LT_LHU   = 3'd4;
    localparam logic [2:0] C_LT_LWL   = 3'd5;
    localparam logic [2:0] C_LT_LWR   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [4:0]        wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        dest_q, dest_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] rt_q, rt_d;

    logic [DATA_W-1:0] w_sel_result;
    logic [DATA_W-1:0] w_load_data;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [4:0]        w_sh_l, w_sh_r;
    logic [DATA_W-1:0] w_mask_l, w_mask_r;

    always_comb begin
        w_sel_result = wb.hilo_value;
        case (wb.wb_src)
            C_SRC_ALU:  w_sel_result = wb.alu_result;
            C_SRC_LINK: w_sel_result = wb.link_addr;
            default:    w_sel_result = wb.hilo_value;
        endcase
    end

    // Lane extraction works on the captured address/type; only the read data is live.
    always_comb begin
        w_sh_r   = {k_q, 3'b000};
        w_sh_l   = {2'd3 - k_q, 3'b000};
        w_byte   = 8'(wb.mem_readdata >> w_sh_r);
        w_half   = k_q[1] ? wb.mem_readdata[31:16] : wb.mem_readdata[15:0];
        w_mask_l = (DATA_W'(1) << w_sh_l) - DATA_W'(1);
        w_mask_r = {DATA_W{1'b1}} >> w_sh_r;
        case (ltype_q)
            C_LT_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            C_LT_LBU: w_load_data = {24'd0, w_byte};
            C_LT_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            C_LT_LHU: w_load_data = {16'd0, w_half};
            C_LT_LWL: w_load_data = (wb.mem_readdata << w_sh_l) | (rt_q & w_mask_l);
            C_LT_LWR: w_load_data = (wb.mem_readdata >> w_sh_r) | (rt_q & ~w_mask_r);
            default:  w_load_data = wb.mem_readdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        count_d = count_q;
        dest_d  = dest_q;
        ltype_d = ltype_q;
        k_d     = k_q;
        rt_d    = rt_q;
        case (state_q)
            S_IDLE: begin
                if (wb.wb_valid) begin
                    dest_d  = wb.dest_reg;
                    ltype_d = wb.load_type;
                    k_d     = wb.byte_addr;
                    rt_d    = wb.rt_old;
                    if (wb.wb_src == C_SRC_LOAD) begin
                        state_d = S_WAIT_MEM;
                    end else begin
                        state_d = S_COMMIT;
                        we_d    = (wb.dest_reg != 5'd0);
                        wreg_d  = wb.dest_reg;
                        wdata_d = w_sel_result;
                        done_d  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT_MEM: begin
                if (!wb.mem_waitrequest) begin
                    state_d = S_COMMIT;
                    we_d    = (dest_q != 5'd0);
                    wreg_d  = dest_q;
                    wdata_d = w_load_data;
                    done_d  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
            dest_q  <= 5'd0;
            ltype_q <= 3'd0;
            k_q     <= 2'd0;
            rt_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            ltype_q <= ltype_d;
            k_q     <= k_d;
            rt_q    <= rt_d;
        end
    end

    assign wb.busy          = busy_q;
    assign wb.write_enable  = we_q;
    assign wb.write_reg     = wreg_q;
    assign wb.write_data    = wdata_q;
    assign wb.wb_done       = done_q;
    assign wb.retired_count = count_q;
endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_writeback_unit.sv
// ============================================================================
//  Module      : tb_mips_cpu_writeback_unit
//  Description : Scoreboard bench for mips_cpu_writeback_unit (narrow counter
//                so that wrap-around is reached quickly).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_writeback_unit;
    localparam int CNT_W = 5;

    typedef struct {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_cpu_writeback_unit_if #(.DATA_W(32), .CNT_W(CNT_W)) wbif ();

    mips_cpu_writeback_unit #(.DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbif)
    );

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load model built lane by lane.
    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] k,
                                               input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  mb[4];
        logic [7:0]  rb[4];
        logic [7:0]  ob[4];
        logic [7:0]  b;
        logic [15:0] h;
        int          kk;
        kk = int'(k);
        for (int i = 0; i < 4; i++) begin
            mb[i] = m[8*i +: 8];
            rb[i] = rt[8*i +: 8];
        end
        b = mb[kk];
        h = {mb[(kk/2)*2+1], mb[(kk/2)*2]};
        case (lt)
            3'd1: return {{24{b[7]}}, b};
            3'd2: return {24'd0, b};
            3'd3: return {{16{h[15]}}, h};
            3'd4: return {16'd0, h};
            3'd5: begin
                for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - kk) ? mb[i - (3 - kk)] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            3'd6: begin
                for (int i = 0; i < 4; i++) ob[i] = (i + kk <= 3) ? mb[i + kk] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            default: return m;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (wbif.write_enable && !wbif.wb_done) check("we_without_done", 32'd1, 32'd0);
            if (wbif.wb_done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    exp_count = exp_count + CNT_W'(1);
                    check("write_enable", 32'(wbif.write_enable), 32'(e.we));
                    check("write_reg", 32'(wbif.write_reg), 32'(e.r));
                    check("write_data", wbif.write_data, e.d);
                    check("retired_count", 32'(wbif.retired_count), 32'(exp_count));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] src, input logic [4:0] dest, input logic [31:0] val,
                         input logic [2:0] lt, input logic [1:0] k, input logic [31:0] rt,
                         input logic [31:0] mem, input int w, input logic [31:0] exp_data,
                         input bit poke);
        int   t;
        int   cyc;
        int   bcnt;
        exp_t e;
        t = 0; cyc = 0; bcnt = 0;
        @(negedge clk);
        while (wbif.busy && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) check("idle_timeout", 32'd1, 32'd0);
        wbif.wb_valid        = 1'b1;
        wbif.wb_src          = src;
        wbif.dest_reg        = dest;
        wbif.alu_result      = (src == 2'd0) ? val : $urandom;
        wbif.link_addr       = (src == 2'd2) ? val : $urandom;
        wbif.hilo_value      = (src == 2'd3) ? val : $urandom;
        wbif.load_type       = lt;
        wbif.byte_addr       = k;
        wbif.rt_old          = rt;
        wbif.mem_waitrequest = 1'b1;
        wbif.mem_readdata    = $urandom;
        e.we = (dest != 5'd0);
        e.r  = dest;
        e.d  = exp_data;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        wbif.wb_src     = 2'($urandom);
        wbif.dest_reg   = 5'($urandom);
        wbif.alu_result = $urandom;
        wbif.link_addr  = $urandom;
        wbif.hilo_value = $urandom;
        wbif.load_type  = 3'($urandom);
        wbif.byte_addr  = 2'($urandom);
        wbif.rt_old     = $urandom;
        while (wbif.busy && cyc < 100) begin
            bcnt++;
            wbif.wb_valid = poke && (cyc == 0);
            if (src == 2'd1 && cyc == w) begin
                wbif.mem_readdata    = mem;
                wbif.mem_waitrequest = 1'b0;
            end else begin
                wbif.mem_readdata    = $urandom;
                wbif.mem_waitrequest = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        wbif.wb_valid        = 1'b0;
        wbif.mem_waitrequest = 1'b1;
        check("busy_len", 32'(bcnt), (src == 2'd1) ? 32'(w + 2) : 32'd1);
    endtask

    initial begin
        logic [1:0]  src;
        logic [2:0]  lt;
        logic [1:0]  k;
        logic [31:0] v, m, rt, ed;
        logic [4:0]  d;
        int          w;

        reset                = 1'b1;
        exp_count            = '0;
        wbif.wb_valid        = 1'b0;
        wbif.wb_src          = 2'd0;
        wbif.dest_reg        = 5'd0;
        wbif.alu_result      = '0;
        wbif.link_addr       = '0;
        wbif.hilo_value      = '0;
        wbif.load_type       = 3'd0;
        wbif.byte_addr       = 2'd0;
        wbif.rt_old          = '0;
        wbif.mem_readdata    = '0;
        wbif.mem_waitrequest = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(wbif.busy), 32'd0);
        check("rst_we", 32'(wbif.write_enable), 32'd0);
        check("rst_done", 32'(wbif.wb_done), 32'd0);
        check("rst_reg", 32'(wbif.write_reg), 32'd0);
        check("rst_data", wbif.write_data, 32'd0);
        check("rst_count", 32'(wbif.retired_count), 32'd0);
        reset = 1'b1;

        issue(2'd0, 5'd8, 32'h1234_5678, 3'd0, 2'd0, 32'd0, 32'd0, 0, 32'h1234_5678, 1'b0);
        issue(2'd1, 5'd5, 32'd0, 3'd1, 2'd2, 32'h5555_5555, 32'h00F3_0000, 3, 32'hFFFF_FFF3, 1'b0);
        issue(2'd1, 5'd6, 32'd0, 3'd2, 2'd2, 32'h5555_5555, 32'h00F3_0000, 3, 32'h0000_00F3, 1'b0);
        issue(2'd1, 5'd9, 32'd0, 3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hCCDD_3344, 1'b0);
        issue(2'd1, 5'd10, 32'd0, 3'd6, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 0, 32'h11AA_BBCC, 1'b0);
        issue(2'd2, 5'd0, 32'hDEAD_0008, 3'd0, 2'd0, 32'd0, 32'd0, 0, 32'hDEAD_0008, 1'b1);
        issue(2'd3, 5'd31, 32'hCAFE_F00D, 3'd0, 2'd0, 32'd0, 32'd0, 0, 32'hCAFE_F00D, 1'b1);
        issue(2'd1, 5'd3, 32'd0, 3'd3, 2'd3, 32'd0, 32'h8001_7FFF, 2, 32'hFFFF_8001, 1'b1);

        // Enough retires to roll the narrow counter over at least once.
        for (int n = 0; n < 40; n++) begin
            src = 2'($urandom);
            d   = 5'($urandom);
            v   = $urandom;
            lt  = 3'($urandom);
            k   = 2'($urandom);
            rt  = $urandom;
            m   = $urandom;
            w   = int'($urandom_range(0, 3));
            ed  = (src == 2'd1) ? model_load(lt, k, m, rt) : v;
            issue(src, d, v, lt, k, rt, m, w, ed, n[0]);
        end
        check("count_after_wrap", 32'(wbif.retired_count), 32'(exp_count));

        @(negedge clk);
        wbif.wb_valid        = 1'b1;
        wbif.wb_src          = 2'd1;
        wbif.dest_reg        = 5'd7;
        wbif.load_type       = 3'd0;
        wbif.mem_waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wbif.wb_valid = 1'b0;
        @(negedge clk);
        check("busy_in_wait", 32'(wbif.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 32'(wbif.busy), 32'd0);
        check("midrst_count", 32'(wbif.retired_count), 32'd0);
        check("midrst_we", 32'(wbif.write_enable), 32'd0);
        exp_count            = '0;
        wbif.mem_waitrequest = 1'b0;
        wbif.mem_readdata    = 32'h0BAD_0BAD;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(wbif.busy), 32'd0);
        check("post_rst_count", 32'(wbif.retired_count), 32'd0);
        wbif.mem_waitrequest = 1'b1;

        issue(2'd0, 5'd1, 32'h0000_0042, 3'd0, 2'd0, 32'd0, 32'd0, 0, 32'h0000_0042, 1'b0);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
